imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction memory: receives a program as a byte stream (valid/ready) and writes
//  16-bit instruction words into the instruction memory at consecutive addresses that fetch later reads.
//  Sits between the host/UART byte link and the imem write port.
//  Holds the core (busy) while a load is in progress.
// PARAMETERS
//  ADDR_W     21   imem word-address width (2M-word memory)
//  INST_W     16   instruction width; fixed at 16 (2 bytes per word)
//  BASE_ADDR  0    first imem word address written
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst        in   1       asynchronous, active-high reset
//  start      in   1       one-cycle pulse: begin a load (ignored unless IDLE or DONE)
//  in_data    in   8       stream byte
//  in_valid   in   1       in_data valid
//  in_ready   out  1       loader accepts byte this cycle
//  mem_we     out  1       imem write strobe (one cycle per word)
//  mem_addr   out  ADDR_W  imem word address
//  mem_wdata  out  16      instruction word {hi_byte, lo_byte}
//  busy       out  1       load in progress; core must hold pc/fetch
//  done       out  1       one-cycle pulse at end of load (success or error)
//  err        out  1       sticky: length overflow or checksum mismatch; cleared by start or rst
//  word_cnt   out  ADDR_W+1 words written in current/last load
// BEHAVIOUR
//  - Reset: all outputs 0 (mem_addr=0, not BASE_ADDR); state IDLE. imem contents untouched.
//  - Byte accepted iff in_valid && in_ready. in_ready=1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO (and CHK).
//  - Stream: LEN (16-bit, hi byte first) = word count N, then N words, each hi byte then lo byte.
//  - FSM: IDLE -start-> LEN_HI -> LEN_LO -> (N==0 ? DONE : DAT_HI) ; DAT_HI -> DAT_LO ;
//    DAT_LO -> DAT_HI while words remain, else DONE (or CHK if checksum enabled) ; DONE -start-> LEN_HI.
//  - Overflow: if N > 2^ADDR_W - BASE_ADDR at LEN_LO accept, err=1, no writes, go to DONE.
//  - Write: lo-byte accept at cycle t -> mem_we=1, mem_addr=BASE_ADDR+k, mem_wdata at t+1 (registered),
//    k = 0..N-1; word_cnt increments in that same cycle. mem_we otherwise 0; addr/wdata hold last value.
//  - done pulses exactly one cycle on entry to DONE (same cycle as last mem_we if no CHK); busy falls
//    the same cycle. busy=1 from cycle after start through the final write/CHK byte.
//  - start while busy: ignored. start in DONE: clears err and word_cnt, restarts.
//  - in_valid low mid-word: hi byte held, no timeout; loader waits indefinitely.
//  - Reset mid-load: immediate return to IDLE; partial words never written; in_ready drops with rst.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: after the N-th word one extra byte is accepted in state CHK;
//    expected = XOR of all data bytes (LEN bytes excluded; 0x00 for N==0, CHK still entered).
//    Mismatch -> err=1 with done. Words already written are not rolled back.
//  Not defined: no CHK state; DAT_LO with last word -> DONE; err only from overflow.
// STRUCTURE
//  Shared package (proc_pkg): INST_W=16, opcode/src/dst/shamt field positions [15:10]/[9:7]/[6:4]/[3:0],
//    IMEM_ADDR_W, loader state enum (IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, CHK, DONE).
//  Sub-module: imem_word_assembler (hi-byte latch + word register + running XOR), instanced once;
//    FSM, address counter and length down-counter remain in imem_loader.
// TESTING
//  1 Reset, start, bytes 00 02 44 F0 0C 10 (in_valid always 1) -> writes addr0=44F0, addr1=0C10,
//    two mem_we pulses, done at 2nd write, word_cnt=2, err=0.
//  2 LEN=0000 -> no mem_we, done one cycle after LEN_LO accept, busy low after.
//  3 Random in_valid gaps (incl. between hi/lo bytes) with N=6 -> identical imem contents to case 1 style
//    reference model, no spurious mem_we.
//  4 LEN > 2^ADDR_W (small ADDR_W=4, LEN=0011) -> err=1, done, zero writes; next start clears err.
//  5 rst asserted after hi byte of word 3 -> in_ready/busy/mem_we 0 same cycle; new load writes from BASE_ADDR.
//  6 CHECKSUM_EN: 00 01 12 34 26 -> done, err=0; same with last byte 27 -> err=1, word still written.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared processor definitions: instruction format, imem geometry and loader state encoding.
package proc_pkg;

  localparam int unsigned INST_W      = 16;
  localparam int unsigned IMEM_ADDR_W = 21;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned LEN_W       = 16;

  localparam int unsigned OPC_HI   = 15;
  localparam int unsigned OPC_LO   = 10;
  localparam int unsigned SRC_HI   = 9;
  localparam int unsigned SRC_LO   = 7;
  localparam int unsigned DST_HI   = 6;
  localparam int unsigned DST_LO   = 4;
  localparam int unsigned SHAMT_HI = 3;
  localparam int unsigned SHAMT_LO = 0;

  typedef struct packed {
    logic [OPC_HI-OPC_LO:0]     opcode;
    logic [SRC_HI-SRC_LO:0]     src;
    logic [DST_HI-DST_LO:0]     dst;
    logic [SHAMT_HI-SHAMT_LO:0] shamt;
  } inst_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DAT_HI,
    DAT_LO,
    CHK,
    DONE
  } loader_state_e;

  // States in which the loader takes a byte from the stream (and holds the core).
  function automatic logic loader_accepts(input loader_state_e st);
    return (st == LEN_HI) || (st == LEN_LO) || (st == DAT_HI) || (st == DAT_LO) || (st == CHK);
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Pairs stream bytes into 16-bit instruction words and keeps a running XOR of all data bytes.
module imem_word_assembler
  import proc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              hi_we,
  input  logic              lo_we,
  input  logic [BYTE_W-1:0] din,
  output logic [INST_W-1:0] word,
  output logic [BYTE_W-1:0] xor_acc
);

  logic [BYTE_W-1:0] hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q    <= '0;
      word    <= '0;
      xor_acc <= '0;
    end else begin
      if (clear) begin
        xor_acc <= '0;
      end else if (hi_we || lo_we) begin
        xor_acc <= xor_acc ^ din;
      end
      if (hi_we) begin
        hi_q <= din;
      end
      if (lo_we) begin
        word <= {hi_q, din};
      end
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader writing 16-bit words into imem at consecutive addresses.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data words.
module imem_loader
  import proc_pkg::*;
#(
  parameter int unsigned ADDR_W    = IMEM_ADDR_W,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [INST_W-1:0] mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_cnt
);

  // Words that fit between BASE_ADDR and the top of imem.
  localparam logic [32:0] LEN_LIMIT = (33'd1 << ADDR_W) - 33'(BASE_ADDR);

  loader_state_e     state, state_nxt;
  logic [BYTE_W-1:0] len_hi;
  logic [LEN_W-1:0]  remain;
  logic [ADDR_W-1:0] addr_cnt;
  logic [BYTE_W-1:0] xor_acc;

  logic              accept_c;
  logic              start_ok_c;
  logic [LEN_W-1:0]  len_full_c;
  logic              len_ovf_c;
  logic              hi_we_c;
  logic              lo_we_c;
  logic              chk_bad_c;

  assign accept_c   = in_valid && in_ready;
  assign start_ok_c = start && ((state == IDLE) || (state == DONE));
  assign len_full_c = {len_hi, in_data};
  assign len_ovf_c  = 33'(len_full_c) > LEN_LIMIT;

  // Next-state and per-cycle strobes.
  always_comb begin
    state_nxt = state;
    hi_we_c   = 1'b0;
    lo_we_c   = 1'b0;
    chk_bad_c = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = LEN_HI;
      end
      LEN_HI: begin
        if (accept_c) state_nxt = LEN_LO;
      end
      LEN_LO: begin
        if (accept_c) begin
          if (len_ovf_c) begin
            state_nxt = DONE;
          end else if (len_full_c == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = CHK;
`else
            state_nxt = DONE;
`endif
          end else begin
            state_nxt = DAT_HI;
          end
        end
      end
      DAT_HI: begin
        if (accept_c) begin
          hi_we_c   = 1'b1;
          state_nxt = DAT_LO;
        end
      end
      DAT_LO: begin
        if (accept_c) begin
          lo_we_c = 1'b1;
          if (remain == LEN_W'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_nxt = CHK;
`else
            state_nxt = DONE;
`endif
          end else begin
            state_nxt = DAT_HI;
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        if (accept_c) begin
          chk_bad_c = (in_data != xor_acc);
          state_nxt = DONE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

`ifndef IMEM_LOADER_CHECKSUM_EN
  logic unused_xor;
  assign unused_xor = ^xor_acc;
`endif

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      word_cnt <= '0;
      len_hi   <= '0;
      remain   <= '0;
      addr_cnt <= '0;
    end else begin
      state    <= state_nxt;
      in_ready <= loader_accepts(state_nxt);
      busy     <= loader_accepts(state_nxt);
      done     <= (state_nxt == DONE) && (state != DONE);
      mem_we   <= lo_we_c;

      if (start_ok_c) begin
        err      <= 1'b0;
        word_cnt <= '0;
        addr_cnt <= ADDR_W'(BASE_ADDR);
      end
      if (state == LEN_HI && accept_c) begin
        len_hi <= in_data;
      end
      if (state == LEN_LO && accept_c) begin
        remain <= len_full_c;
        if (len_ovf_c) err <= 1'b1;
      end
      if (lo_we_c) begin
        mem_addr <= addr_cnt;
        addr_cnt <= addr_cnt + ADDR_W'(1);
        word_cnt <= word_cnt + (ADDR_W+1)'(1);
        remain   <= remain - LEN_W'(1);
      end
      if (chk_bad_c) begin
        err <= 1'b1;
      end
    end
  end

  imem_word_assembler u_asm (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_ok_c),
    .hi_we   (hi_we_c),
    .lo_we   (lo_we_c),
    .din     (in_data),
    .word    (mem_wdata),
    .xor_acc (xor_acc)
  );

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (small imem: ADDR_W=4, BASE_ADDR=0).
// Checksum cases run only when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int unsigned ADDR_W = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [7:0]        in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   word_cnt;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned we_cnt = 0;
  int unsigned done_cnt = 0;
  logic        done_with_we = 1'b0;
  logic [31:0] sb[$];
  logic [15:0] prog[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .word_cnt  (word_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write monitor: every mem_we must match the oldest expected write.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        we_cnt++;
        if (sb.size() == 0) begin
          check("spurious_we", 32'(mem_we), 32'd0);
        end else begin
          logic [31:0] e;
          e = sb.pop_front();
          check("wr_addr", 32'(mem_addr), {16'd0, e[31:16]});
          check("wr_data", 32'(mem_wdata), {16'd0, e[15:0]});
        end
      end
      if (done) begin
        done_cnt++;
        done_with_we = mem_we;
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    int unsigned n;
    n = 0;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  function automatic int unsigned gap_of(input int unsigned gmax);
    return (gmax == 0) ? 0 : $urandom_range(gmax, 0);
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Full load of prog[0..n-1]; ovf loads send only the length field.
  task automatic load(input logic [15:0] n, input int unsigned gmax, input bit ovf, input bit bad_chk);
    logic [7:0]  x;
    logic [15:0] w;
    int unsigned d0;
    int unsigned t;
    x  = '0;
    d0 = done_cnt;
    pulse_start();
    check("busy_after_start", 32'(busy), 32'd1);
    check("err_cleared", 32'(err), 32'd0);
    send_byte(n[15:8], gap_of(gmax));
    send_byte(n[7:0], gap_of(gmax));
    if (!ovf) begin
      for (int k = 0; k < int'(n); k++) begin
        w = prog[k];
        x = x ^ w[15:8] ^ w[7:0];
        send_byte(w[15:8], gap_of(gmax));
        sb.push_back({16'(k), w});
        send_byte(w[7:0], gap_of(gmax));
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      send_byte(bad_chk ? (x ^ 8'h01) : x, gap_of(gmax));
`endif
    end
    t = 0;
    while (done_cnt == d0 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", 32'(done_cnt - d0), 32'd1);
    @(negedge clk);
    check("busy_after_done", 32'(busy), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int unsigned w0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_word_cnt", 32'(word_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Two back-to-back words, no gaps.
    prog = '{16'h44F0, 16'h0C10};
    w0 = we_cnt;
    load(16'd2, 0, 1'b0, 1'b0);
    check("t1_we_count", 32'(we_cnt - w0), 32'd2);
    check("t1_word_cnt", 32'(word_cnt), 32'd2);
    check("t1_err", 32'(err), 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check("t1_done_with_last_we", 32'(done_with_we), 32'd1);
`endif

    // Zero-length program.
    w0 = we_cnt;
`ifdef IMEM_LOADER_CHECKSUM_EN
    load(16'd0, 0, 1'b0, 1'b0);
`else
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    check("t2_done_next_cycle", 32'(done), 32'd1);
    check("t2_busy_low", 32'(busy), 32'd0);
`endif
    check("t2_we_count", 32'(we_cnt - w0), 32'd0);
    check("t2_word_cnt", 32'(word_cnt), 32'd0);

    // Random data with random in_valid gaps.
    prog.delete();
    for (int k = 0; k < 6; k++) prog.push_back(16'($urandom));
    w0 = we_cnt;
    load(16'd6, 3, 1'b0, 1'b0);
    check("t3_we_count", 32'(we_cnt - w0), 32'd6);
    check("t3_word_cnt", 32'(word_cnt), 32'd6);

    // Length overflow: 17 words into a 16-word imem.
    w0 = we_cnt;
    load(16'h0011, 0, 1'b1, 1'b0);
    check("t4_err", 32'(err), 32'd1);
    check("t4_we_count", 32'(we_cnt - w0), 32'd0);
    check("t4_word_cnt", 32'(word_cnt), 32'd0);

    // Exactly full imem is legal; start also clears the sticky err.
    prog.delete();
    for (int k = 0; k < 16; k++) prog.push_back(16'($urandom));
    w0 = we_cnt;
    load(16'h0010, 1, 1'b0, 1'b0);
    check("t4b_err", 32'(err), 32'd0);
    check("t4b_we_count", 32'(we_cnt - w0), 32'd16);
    check("t4b_word_cnt", 32'(word_cnt), 32'd16);

    // Reset after the hi byte of word 3.
    prog.delete();
    for (int k = 0; k < 4; k++) prog.push_back(16'($urandom));
    w0 = we_cnt;
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h04, 0);
    for (int k = 0; k < 3; k++) begin
      send_byte(prog[k][15:8], 1);
      sb.push_back({16'(k), prog[k]});
      send_byte(prog[k][7:0], 1);
    end
    send_byte(prog[3][15:8], 0);
    check("t5_sb_before_rst", 32'(sb.size()), 32'd0);
    rst = 1'b1;
    #1;
    check("t5_in_ready", 32'(in_ready), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_mem_we", 32'(mem_we), 32'd0);
    check("t5_word_cnt", 32'(word_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_we_count", 32'(we_cnt - w0), 32'd3);
    prog = '{16'hA5A5, 16'h5A5A};
    load(16'd2, 0, 1'b0, 1'b0);
    check("t5_reload_word_cnt", 32'(word_cnt), 32'd2);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum match (12^34 = 26) and mismatch.
    prog = '{16'h1234};
    load(16'd1, 0, 1'b0, 1'b0);
    check("t6_err_ok", 32'(err), 32'd0);
    w0 = we_cnt;
    load(16'd1, 0, 1'b0, 1'b1);
    check("t6_err_bad", 32'(err), 32'd1);
    check("t6_word_written", 32'(we_cnt - w0), 32'd1);
`endif

    check("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got 0 expected 1");
    $fatal(1);
  end

endmodule
